shift_sequencer: RTL and testbench

- Multi-cycle left-shift unit for the 8-bit datapath.
- Accepts an operand and a shift amount over a valid/ready handshake.
- Shifts the operand by feeding it through the existing single-position left shifter, ShiftLeft (X -> Z), once per clock, N times.
- Returns the result with carry-out and zero flags over a second valid/ready handshake; sits between the register-file read stage and the ALU result mux.

---
 rtl/shift_pkg.sv | 17 +
 rtl/ShiftLeft.sv | 10 +
 rtl/shift_sequencer.sv | 99 +++++++++
 tb/tb_shift_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle left-shift sequencer:
// state encoding, state enum and datapath width.
package shift_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/ShiftLeft.sv
// Single-position left shifter for the 8-bit datapath, zero fill.
// Ports: X - operand in, Z - X shifted left by one.
module ShiftLeft (
    input  logic [7:0] X,
    output logic [7:0] Z
);

    assign Z = {X[6:0], 1'b0};

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle left shifter: accepts operand+amount, shifts one place per clock
// through ShiftLeft, returns result with carry-out and zero flags.
// Ports: clk, rst (async high), clr (sync abort),
//   in_valid/in_ready/in_data/in_amt  - operation request handshake,
//   out_valid/out_ready/out_data/out_carry/out_zero - result handshake,
//   busy - high whenever the sequencer is not idle.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             busy
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d, shl_z;
    logic [AMT_W-1:0]    cnt_q, cnt_d;
    logic                carry_q, carry_d;

    ShiftLeft u_shl (
        .X(data_q),
        .Z(shl_z)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = in_amt;
                    carry_d = 1'b0;
                    // zero amount skips SHIFT so cnt never wraps
                    state_d = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                carry_d = data_q[DATA_W-1];
                data_d  = shl_z;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // abort wins over every transition
        if (clr) begin
            state_d = IDLE;
            data_d  = '0;
            cnt_d   = '0;
            carry_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign out_zero  = (data_q == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: vector table plus scoreboard queue,
// with hand-written backpressure, reset and abort sequences.
module tb_shift_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, in_valid, in_valid4, out_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [3:0] in_amt4;

    logic       in_ready, out_valid, out_carry, out_zero, busy;
    logic [7:0] out_data;
    logic       in_ready4, out_valid4, out_carry4, out_zero4, busy4;
    logic [7:0] out_data4;

    shift_sequencer dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry),
        .out_zero(out_zero), .busy(busy)
    );

    shift_sequencer #(.AMT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data), .in_amt(in_amt4),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_carry(out_carry4),
        .out_zero(out_zero4), .busy(busy4)
    );

    typedef struct {
        bit         w;
        logic [7:0] d;
        logic [3:0] a;
        logic [7:0] ed;
        logic       ec;
        logic       ez;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       z;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic o_ready(bit w);
        return w ? in_ready4 : in_ready;
    endfunction
    function automatic logic o_valid(bit w);
        return w ? out_valid4 : out_valid;
    endfunction
    function automatic logic o_busy(bit w);
        return w ? busy4 : busy;
    endfunction
    function automatic logic [7:0] o_data(bit w);
        return w ? out_data4 : out_data;
    endfunction
    function automatic logic o_carry(bit w);
        return w ? out_carry4 : out_carry;
    endfunction
    function automatic logic o_zero(bit w);
        return w ? out_zero4 : out_zero;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit w, input logic [7:0] d,
                         input logic [3:0] a, input exp_t e);
        int k = 0;
        in_data = d;
        in_amt  = a[2:0];
        in_amt4 = a;
        if (w) in_valid4 = 1'b1;
        else   in_valid  = 1'b1;
        while (!o_ready(w) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready never high");
        end
        @(posedge clk);
        sb.push_back(e);
        #1;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        @(negedge clk);
    endtask

    // Counts edges until out_valid, then pops and compares the result.
    task automatic collect(input bit w, input int exp_lat, input string tag);
        int   lat = 0;
        exp_t e;
        while (!o_valid(w) && lat < 40) begin
            check({tag, " busy"}, o_busy(w), 1);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, lat, exp_lat);
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s scoreboard: result with nothing expected", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " data"}, o_data(w), e.d);
            check({tag, " carry"}, o_carry(w), e.c);
            check({tag, " zero"}, o_zero(w), e.z);
        end
    endtask

    initial begin
        vecs[0]  = '{0, 8'h81, 4'd1, 8'h02, 1'b1, 1'b0};
        vecs[1]  = '{0, 8'hA5, 4'd0, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{0, 8'h01, 4'd7, 8'h80, 1'b0, 1'b0};
        vecs[3]  = '{0, 8'hC3, 4'd2, 8'h0C, 1'b1, 1'b0};
        vecs[4]  = '{0, 8'hFF, 4'd7, 8'h80, 1'b1, 1'b0};
        vecs[5]  = '{0, 8'h00, 4'd3, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{0, 8'h55, 4'd4, 8'h50, 1'b1, 1'b0};
        vecs[7]  = '{0, 8'h40, 4'd2, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{0, 8'h3C, 4'd3, 8'hE0, 1'b1, 1'b0};
        vecs[9]  = '{0, 8'h12, 4'd5, 8'h40, 1'b0, 1'b0};
        vecs[10] = '{1, 8'h01, 4'd8, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{1, 8'h01, 4'd9, 8'h00, 1'b0, 1'b1};
        vecs[12] = '{1, 8'hF0, 4'd4, 8'h00, 1'b1, 1'b1};
        vecs[13] = '{1, 8'h80, 4'd15, 8'h00, 1'b0, 1'b1};

        rst = 1'b1; clr = 1'b0;
        in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
        in_data = '0; in_amt = '0; in_amt4 = '0;
        #3;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_carry", out_carry, 0);
        check("rst out_zero", out_zero, 1);
        check("rst busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].w, vecs[i].d, vecs[i].a,
                  '{vecs[i].ed, vecs[i].ec, vecs[i].ez});
            collect(vecs[i].w, int'(vecs[i].a), $sformatf("v%0d", i));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d idle ready", i), o_ready(vecs[i].w), 1);
            check($sformatf("v%0d idle valid", i), o_valid(vecs[i].w), 0);
        end

        // backpressure: result held, pending request not captured
        out_ready = 1'b0;
        issue(0, 8'hC3, 4'd2, '{8'h0C, 1'b1, 1'b0});
        collect(0, 2, "bp");
        in_data  = 8'h11;
        in_amt   = 3'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp hold valid", out_valid, 1);
            check("bp hold data", out_data, 8'h0C);
            check("bp hold carry", out_carry, 1);
            check("bp in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp bubble ready", in_ready, 1);
        check("bp bubble valid", out_valid, 0);
        @(posedge clk);
        sb.push_back('{8'h22, 1'b0, 1'b0});
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        collect(0, 1, "bp next");
        @(posedge clk);
        @(negedge clk);

        // asynchronous reset mid-shift
        issue(0, 8'hFF, 4'd7, '{8'h80, 1'b1, 1'b0});
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst out_valid", out_valid, 0);
        check("arst out_data", out_data, 0);
        check("arst busy", busy, 0);
        check("arst in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst after ready", in_ready, 1);

        // synchronous abort mid-shift
        issue(0, 8'hFF, 4'd7, '{8'h80, 1'b1, 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        check("clr pre busy", busy, 1);
        @(posedge clk);
        #1;
        check("clr out_valid", out_valid, 0);
        check("clr out_data", out_data, 0);
        check("clr busy", busy, 0);
        check("clr in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        clr = 1'b0;

        // abort of a pending result
        out_ready = 1'b0;
        issue(0, 8'h81, 4'd1, '{8'h02, 1'b1, 1'b0});
        collect(0, 1, "clr done");
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr done valid", out_valid, 0);
        check("clr done data", out_data, 0);
        check("clr done carry", out_carry, 0);
        @(negedge clk);
        clr = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("clr done ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
